// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the sum accumulator and its neighbours: the upstream
// sum feed, the downstream batch-total feed, and the status outputs.
interface adder_sum_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 4
);
  logic             clear;
  logic [3:0]       sum_in;
  logic             sum_valid;
  logic             sum_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [CNT_W-1:0] batch_cnt;
  logic             overflow;

  modport master (
    output clear, sum_in, sum_valid, acc_ready,
    input  sum_ready, acc_out, acc_valid, batch_cnt, overflow
  );

  modport slave (
    input  clear, sum_in, sum_valid, acc_ready,
    output sum_ready, acc_out, acc_valid, batch_cnt, overflow
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates BATCH 4-bit sums and presents each batch total under valid/ready.
// Define ADDER_ACC_SATURATE_EN to clamp on carry-out instead of wrapping.
//
// state    | meaning
// ST_ACCUM | accepting sums into acc_q, batch total not yet available
// ST_HOLD  | acc_out_q holds a finished batch until drained or cleared
module adder_sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int BATCH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  adder_sum_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_valid_q, acc_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_full;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             accept;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // One extra bit exposes the carry that drives the sticky overflow.
  always_comb begin
    sum_full = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, bus.sum_in};
    carry    = sum_full[ACC_W];
`ifdef ADDER_ACC_SATURATE_EN
    acc_next = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    acc_next = sum_full[ACC_W-1:0];
`endif
    accept   = bus.sum_valid && (state_q == ST_ACCUM);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (bus.clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          ovf_d = ovf_q | carry;
          if (cnt_q == LAST) begin
            acc_out_d   = acc_next;
            acc_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        // Clear drops the pending result even if the consumer is taking it.
        if (bus.clear) begin
          acc_out_d   = '0;
          acc_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_ACCUM;
        end else if (bus.acc_ready) begin
          acc_valid_d = 1'b0;
          acc_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    bus.sum_ready = (state_q == ST_ACCUM);
    bus.acc_valid = acc_valid_q;
    bus.acc_out   = acc_out_q;
    bus.batch_cnt = cnt_q;
    bus.overflow  = ovf_q;
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: three instances (8-bit/4-sum, 5-bit/4-sum,
// 8-bit/1-sum) checked every cycle against a batch-level model plus literal values.
module tb_adder_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_sum_accumulator_if #(.ACC_W(8), .CNT_W(4)) i8 ();
  adder_sum_accumulator_if #(.ACC_W(5), .CNT_W(4)) i5 ();
  adder_sum_accumulator_if #(.ACC_W(8), .CNT_W(4)) i1 ();

  adder_sum_accumulator #(.ACC_W(8), .BATCH(4), .CNT_W(4)) u8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(i8.slave));
  adder_sum_accumulator #(.ACC_W(5), .BATCH(4), .CNT_W(4)) u5 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(i5.slave));
  adder_sum_accumulator #(.ACC_W(8), .BATCH(1), .CNT_W(4)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(i1.slave));

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  typedef struct {
    int acc;
    int cnt;
    bit hold;
    int out;
    bit ovf;
  } mdl_t;

  mdl_t m[3];

  function automatic mdl_t step(mdl_t s, int w, int b, bit r, bit clr,
                                bit sv, int sin, bit ar);
    mdl_t n;
    int   maxv;
    int   t;
    n    = s;
    maxv = (1 << w) - 1;
    if (r) begin
      n = '{0, 0, 1'b0, 0, 1'b0};
    end else if (!s.hold) begin
      if (clr) begin
        n.acc = 0; n.cnt = 0; n.ovf = 1'b0;
      end else if (sv) begin
        t = s.acc + sin;
        if (t > maxv) begin
          n.ovf = 1'b1;
`ifdef ADDER_ACC_SATURATE_EN
          t = maxv;
`else
          t = t % (maxv + 1);
`endif
        end
        if (s.cnt == b - 1) begin
          n.out = t; n.hold = 1'b1; n.cnt = 0; n.acc = 0;
        end else begin
          n.acc = t; n.cnt = s.cnt + 1;
        end
      end
    end else if (clr) begin
      n.hold = 1'b0; n.out = 0; n.acc = 0; n.ovf = 1'b0;
    end else if (ar) begin
      n.hold = 1'b0; n.acc = 0; n.ovf = 1'b0;
    end
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic sr, logic av, int ao, int bc, logic ov);
    chk($sformatf("d%0d_sum_ready", i), int'(sr), int'(!m[i].hold));
    chk($sformatf("d%0d_acc_valid", i), int'(av), int'(m[i].hold));
    chk($sformatf("d%0d_acc_out", i),   ao, m[i].out);
    chk($sformatf("d%0d_batch_cnt", i), bc, m[i].cnt);
    chk($sformatf("d%0d_overflow", i),  int'(ov), int'(m[i].ovf));
  endtask

  always @(posedge clk) begin
    if (rst) armed = 1'b1;
    m[0] = step(m[0], 8, 4, rst, i8.clear, i8.sum_valid, int'(i8.sum_in), i8.acc_ready);
    m[1] = step(m[1], 5, 4, rst, i5.clear, i5.sum_valid, int'(i5.sum_in), i5.acc_ready);
    m[2] = step(m[2], 8, 1, rst, i1.clear, i1.sum_valid, int'(i1.sum_in), i1.acc_ready);
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, i8.sum_ready, i8.acc_valid, int'(i8.acc_out), int'(i8.batch_cnt), i8.overflow);
      cmp(1, i5.sum_ready, i5.acc_valid, int'(i5.acc_out), int'(i5.batch_cnt), i5.overflow);
      cmp(2, i1.sum_ready, i1.acc_valid, int'(i1.acc_out), int'(i1.batch_cnt), i1.overflow);
    end
  end

  task automatic send8(int v);
    i8.sum_valid = 1'b1;
    i8.sum_in    = 4'(v);
    @(negedge clk);
  endtask

  task automatic send5(int v);
    i5.sum_valid = 1'b1;
    i5.sum_in    = 4'(v);
    @(negedge clk);
  endtask

  initial begin
    int b8[4];
    b8 = '{3, 6, 6, 1};
    i8.clear = 0; i8.sum_in = 0; i8.sum_valid = 0; i8.acc_ready = 0;
    i5.clear = 0; i5.sum_in = 0; i5.sum_valid = 0; i5.acc_ready = 0;
    i1.clear = 0; i1.sum_in = 0; i1.sum_valid = 0; i1.acc_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sum_ready", int'(i8.sum_ready), 1);
    chk("rst_acc_out", int'(i8.acc_out), 0);
    rst = 1'b0;

    // basic batch with consumer always ready
    i8.acc_ready = 1'b1;
    foreach (b8[k]) send8(b8[k]);
    i8.sum_valid = 1'b0;
    chk("t1_acc_valid", int'(i8.acc_valid), 1);
    chk("t1_acc_out", int'(i8.acc_out), 16);
    chk("t1_overflow", int'(i8.overflow), 0);
    chk("t1_sum_ready_hold", int'(i8.sum_ready), 0);
    @(negedge clk);
    chk("t1_valid_drop", int'(i8.acc_valid), 0);
    chk("t1_sum_ready_back", int'(i8.sum_ready), 1);

    // backpressure: sum_valid held while result waits
    i8.acc_ready = 1'b0;
    foreach (b8[k]) send8(b8[k]);
    i8.sum_valid = 1'b1;
    i8.sum_in    = 4'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_sum_ready", int'(i8.sum_ready), 0);
      chk("t2_acc_out", int'(i8.acc_out), 16);
      chk("t2_batch_cnt", int'(i8.batch_cnt), 0);
    end
    i8.acc_ready = 1'b1;
    @(negedge clk);
    chk("t2_drained", int'(i8.acc_valid), 0);
    @(negedge clk);
    chk("t2_next_cnt", int'(i8.batch_cnt), 1);
    i8.sum_valid = 1'b0;
    i8.clear     = 1'b1;
    @(negedge clk);
    i8.clear = 1'b0;

    // clear mid-batch discards a simultaneous sum
    send8(5);
    send8(5);
    chk("t3_cnt_before", int'(i8.batch_cnt), 2);
    i8.clear = 1'b1;
    send8(7);
    i8.clear     = 1'b0;
    i8.sum_valid = 1'b0;
    chk("t3_cnt_cleared", int'(i8.batch_cnt), 0);
    for (int k = 0; k < 4; k++) send8(1);
    i8.sum_valid = 1'b0;
    chk("t3_acc_out", int'(i8.acc_out), 4);
    @(negedge clk);

    // clear, then reset, while holding a result
    i8.acc_ready = 1'b0;
    foreach (b8[k]) send8(b8[k]);
    i8.sum_valid = 1'b0;
    chk("t4_hold_out", int'(i8.acc_out), 16);
    i8.clear     = 1'b1;
    i8.acc_ready = 1'b1;
    @(negedge clk);
    i8.clear     = 1'b0;
    i8.acc_ready = 1'b0;
    chk("t4_clr_valid", int'(i8.acc_valid), 0);
    chk("t4_clr_out", int'(i8.acc_out), 0);
    chk("t4_clr_ready", int'(i8.sum_ready), 1);
    foreach (b8[k]) send8(b8[k]);
    i8.sum_valid = 1'b0;
    chk("t4_hold_again", int'(i8.acc_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_out", int'(i8.acc_out), 0);
    chk("t4_rst_valid", int'(i8.acc_valid), 0);
    chk("t4_rst_cnt", int'(i8.batch_cnt), 0);
    chk("t4_rst_ovf", int'(i8.overflow), 0);
    chk("t4_rst_ready", int'(i8.sum_ready), 1);

    // overflow on the 5-bit instance
    for (int k = 0; k < 2; k++) send5(15);
    chk("t5_no_ovf_yet", int'(i5.overflow), 0);
    send5(15);
    chk("t5_ovf_mid", int'(i5.overflow), 1);
    send5(15);
    i5.sum_valid = 1'b0;
`ifdef ADDER_ACC_SATURATE_EN
    chk("t5_acc_out", int'(i5.acc_out), 31);
`else
    chk("t5_acc_out", int'(i5.acc_out), 28);
`endif
    chk("t5_ovf", int'(i5.overflow), 1);
    i5.acc_ready = 1'b1;
    @(negedge clk);
    chk("t5_ovf_drained", int'(i5.overflow), 0);

    // single-sum batches
    i1.acc_ready = 1'b1;
    i1.sum_valid = 1'b1;
    i1.sum_in    = 4'd9;
    @(negedge clk);
    i1.sum_in = 4'd4;
    chk("t6_out9", int'(i1.acc_out), 9);
    chk("t6_valid9", int'(i1.acc_valid), 1);
    chk("t6_ready_hold9", int'(i1.sum_ready), 0);
    @(negedge clk);
    chk("t6_drop9", int'(i1.acc_valid), 0);
    chk("t6_ready_back", int'(i1.sum_ready), 1);
    @(negedge clk);
    i1.sum_valid = 1'b0;
    chk("t6_out4", int'(i1.acc_out), 4);
    chk("t6_valid4", int'(i1.acc_valid), 1);
    chk("t6_ready_hold4", int'(i1.sum_ready), 0);
    @(negedge clk);
    chk("t6_drop4", int'(i1.acc_valid), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
